sqr_u16: RTL and testbench

//  Pipelined unsigned squarer; the inverse of sqrt_u32.
//  - Maps a W-bit root x to its 2W-bit square y = x*x. Accepts one operand per cycle.
//  - Sits after sqrt_u32 as an on-chip back-check path (root -> square), and serves as
//    a golden square generator in the sqrt benches.

---
 rtl/sqr_u16_pkg.sv | 18 +
 rtl/sqr_u16_if.sv | 25 ++
 rtl/sqr_u16_stage.sv | 73 +++++++
 rtl/sqr_u16.sv | 79 +++++++
 tb/tb_sqr_u16.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sqr_u16_pkg.sv
// sqr_pkg: shared definitions for the sqr_u16 squarer.
//   SQR_W_DEF   default operand width (root width; square is 2*W bits)
//   sqr_stage_t record of what one pipeline stage holds, at the default width.
// Build option: SQR_U16_CHK_EN adds the carried radicand (x_ref) to the record.
package sqr_pkg;

    localparam int SQR_W_DEF = 16;

    typedef struct packed {
        logic                       vld;
        logic [SQR_W_DEF-1:0]       x;
        logic [2*SQR_W_DEF-1:0]     acc;
`ifdef SQR_U16_CHK_EN
        logic [2*SQR_W_DEF-1:0]     x_ref;
`endif
    } sqr_stage_t;

endpackage

// File: rtl/sqr_u16_if.sv
// sqr_u16_if: operand/result bundle of the squarer.
//   vld_in, x        operand strobe and unsigned root (master -> slave)
//   vld_out, y       result strobe and unsigned square (slave -> master)
//   x_ref, err       radicand in / back-check flag out, only when SQR_U16_CHK_EN
// Modports: master = producer of operands (bench or upstream sqrt), slave = sqr_u16.
interface sqr_u16_if
    import sqr_pkg::*;
#(
    parameter int W = SQR_W_DEF
);
    logic               vld_in;
    logic [W-1:0]       x;
    logic               vld_out;
    logic [2*W-1:0]     y;
`ifdef SQR_U16_CHK_EN
    logic [2*W-1:0]     x_ref;
    logic               err;

    modport master (output vld_in, x, x_ref, input vld_out, y, err);
    modport slave  (input vld_in, x, x_ref, output vld_out, y, err);
`else
    modport master (output vld_in, x, input vld_out, y);
    modport slave  (input vld_in, x, output vld_out, y);
`endif
endinterface

// File: rtl/sqr_u16_stage.sv
// sqr_stage: one registered shift-add step of the squarer.
//   Stage K adds (x << K) to the running accumulator when bit K of x is set.
//   Stage 0 is fed a zero accumulator, so it yields x[0] ? x : 0.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   vld, x, acc       incoming stage contents
//   vld_p, x_p, acc_p registered stage contents
//   x_ref, x_ref_p    carried radicand, only when SQR_U16_CHK_EN
// KEEP_X=0 drops the x register (last stage when nothing downstream needs x).
// Data registers load only on a valid beat so the final accumulator holds the
// last valid square through bubbles.
module sqr_stage
    import sqr_pkg::*;
#(
    parameter int W      = SQR_W_DEF,
    parameter int K      = 0,
    parameter bit KEEP_X = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    input  logic [W-1:0]   x,
    input  logic [2*W-1:0] acc,
`ifdef SQR_U16_CHK_EN
    input  logic [2*W-1:0] x_ref,
    output logic [2*W-1:0] x_ref_p,
`endif
    output logic           vld_p,
    output logic [W-1:0]   x_p,
    output logic [2*W-1:0] acc_p
);

    logic [2*W-1:0] addend;

    // Partial product for this bit; the total is bounded by (2^W-1)^2, so no carry-out.
    assign addend = x[K] ? ({{W{1'b0}}, x} << K) : '0;

    // Stage K boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= 1'b0;
            acc_p <= '0;
        end else begin
            vld_p <= vld;
            if (vld) begin
                acc_p <= acc + addend;
            end
        end
    end

    if (KEEP_X) begin : g_keep_x
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x_p <= '0;
            end else if (vld) begin
                x_p <= x;
            end
        end
    end else begin : g_drop_x
        assign x_p = '0;
    end

`ifdef SQR_U16_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_ref_p <= '0;
        end else if (vld) begin
            x_ref_p <= x_ref;
        end
    end
`endif

endmodule

// File: rtl/sqr_u16.sv
// sqr_u16: pipelined unsigned squarer, y = x*x, one operand per cycle.
//   W shift-add stages; a vld_in sampled at edge n shows as vld_out after edge n+W-1.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears every stage and drops in-flight work
//   bus   sqr_u16_if.slave: vld_in, x in; vld_out, y out (x_ref in, err out with check)
// Build option SQR_U16_CHK_EN: carries the radicand x_ref beside each operand and
// raises err on a valid output whose root is not floor(sqrt(x_ref)), i.e. unless
// y <= x_ref and x_ref - y <= 2*x.
module sqr_u16
    import sqr_pkg::*;
#(
    parameter int W = SQR_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    sqr_u16_if.slave bus
);

`ifdef SQR_U16_CHK_EN
    localparam bit KEEP_LAST_X = 1'b1;
`else
    localparam bit KEEP_LAST_X = 1'b0;
`endif

    // Index k is the input of stage k; index W is the pipeline output.
    logic           vld_c [0:W];
    logic [W-1:0]   x_c   [0:W];
    logic [2*W-1:0] acc_c [0:W];
`ifdef SQR_U16_CHK_EN
    logic [2*W-1:0] x_ref_c [0:W];

    assign x_ref_c[0] = bus.x_ref;
`endif

    assign vld_c[0] = bus.vld_in;
    assign x_c[0]   = bus.x;
    assign acc_c[0] = '0;

    for (genvar k = 0; k < W; k++) begin : g_stage
        sqr_stage #(
            .W      (W),
            .K      (k),
            .KEEP_X ((k < W - 1) || KEEP_LAST_X)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .vld     (vld_c[k]),
            .x       (x_c[k]),
            .acc     (acc_c[k]),
`ifdef SQR_U16_CHK_EN
            .x_ref   (x_ref_c[k]),
            .x_ref_p (x_ref_c[k+1]),
`endif
            .vld_p   (vld_c[k+1]),
            .x_p     (x_c[k+1]),
            .acc_p   (acc_c[k+1])
        );
    end

    assign bus.vld_out = vld_c[W];
    assign bus.y       = acc_c[W];

`ifdef SQR_U16_CHK_EN
    // True when root is not the integer square root of ref_v.
    function automatic logic root_bad(input logic [2*W-1:0] sq,
                                      input logic [2*W-1:0] ref_v,
                                      input logic [W-1:0]   root);
        logic [2*W-1:0] twice;
        logic [2*W-1:0] diff;
        twice = {{(W-1){1'b0}}, root, 1'b0};
        diff  = ref_v - sq;
        return !((sq <= ref_v) && (diff <= twice));
    endfunction

    assign bus.err = vld_c[W] && root_bad(acc_c[W], x_ref_c[W], x_c[W]);
`endif

endmodule

// File: tb/tb_sqr_u16.sv
// tb_sqr_u16: scoreboard bench for sqr_u16. Expected squares (and err with
// SQR_U16_CHK_EN) are queued when operands are driven and compared on vld_out.
module tb_sqr_u16;
    import sqr_pkg::*;

    localparam int W = SQR_W_DEF;

    typedef struct {
        logic [2*W-1:0] y;
        logic           err;
        int             stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic [2*W-1:0] last_y = '0;

    sqr_u16_if #(.W(W)) bus ();

    sqr_u16 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] isqrt(input logic [2*W-1:0] r);
        logic [63:0] res;
        logic [63:0] t;
        res = 0;
        for (int b = W - 1; b >= 0; b--) begin
            t = res | (64'd1 << b);
            if (t * t <= {32'd0, r}) res = t;
        end
        return res[W-1:0];
    endfunction

    function automatic logic model_err(input logic [W-1:0] xv, input logic [2*W-1:0] rv);
        longint sq;
        longint rr;
        sq = longint'(xv) * longint'(xv);
        rr = longint'(rv);
        return !(sq <= rr && (rr - sq) <= 2 * longint'(xv));
    endfunction

    task automatic send(input logic [W-1:0] xv, input logic [2*W-1:0] rv);
        exp_t e;
        @(posedge clk);
        #1;
        bus.vld_in = 1'b1;
        bus.x      = xv;
`ifdef SQR_U16_CHK_EN
        bus.x_ref  = rv;
        e.err      = model_err(xv, rv);
`else
        e.err      = 1'b0;
`endif
        e.y        = (2*W)'(longint'(xv) * longint'(xv));
        e.stamp    = cyc + 1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.vld_in = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * W && q.size() != 0; i++) @(posedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        idle(4);
    endtask

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_vld", 64'(bus.vld_out), 64'd0);
            chk("rst_y", 64'(bus.y), 64'd0);
`ifdef SQR_U16_CHK_EN
            chk("rst_err", 64'(bus.err), 64'd0);
`endif
            last_y = '0;
        end else if (bus.vld_out) begin
            if (q.size() == 0) begin
                chk("spurious_vld", 64'(bus.vld_out), 64'd0);
            end else begin
                e = q.pop_front();
                chk("y", 64'(bus.y), 64'(e.y));
                chk("latency", 64'(cyc - e.stamp), 64'(W - 1));
`ifdef SQR_U16_CHK_EN
                chk("err", 64'(bus.err), 64'(e.err));
`endif
                last_y = e.y;
            end
        end else begin
            chk("hold_y", 64'(bus.y), 64'(last_y));
`ifdef SQR_U16_CHK_EN
            chk("idle_err", 64'(bus.err), 64'd0);
`endif
        end
    end

    initial begin
        logic [W-1:0]   xv;
        logic [2*W-1:0] rv;
        bus.vld_in = 1'b0;
        bus.x      = '0;
`ifdef SQR_U16_CHK_EN
        bus.x_ref  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single operand
        send(16'h0003, 32'd9);
        idle(W + 4);
        drain();

        // Back-to-back boundary operands
        send(16'h0000, 32'h0);
        send(16'h0001, 32'h1);
        send(16'hFFFF, 32'hFFFE0001);
        send(16'h8000, 32'h40000000);
        idle(1);
        drain();

        // Random operands every second cycle
        for (int i = 0; i < 16; i++) begin
            xv = 16'($urandom_range(0, 65535));
            send(xv, (2*W)'(longint'(xv) * longint'(xv)));
            idle(1);
        end
        drain();

        // Reset with work in flight
        for (int i = 0; i < 5; i++) begin
            xv = 16'($urandom_range(0, 65535));
            send(xv, (2*W)'(longint'(xv) * longint'(xv)));
        end
        @(posedge clk);
        #1;
        bus.vld_in = 1'b0;
        rst = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(W + 4);
        send(16'd7, 32'd49);
        idle(1);
        drain();

`ifdef SQR_U16_CHK_EN
        // Back-check boundaries around 0x1000^2
        send(16'h1000, 32'h01000000);
        send(16'h1000, 32'h01001FFF);
        send(16'h1000, 32'h01002001);
        idle(1);
        drain();

        // Roots from an integer square-root model
        for (int i = 0; i < 20; i++) begin
            rv = 32'($urandom());
            send(isqrt(rv), rv);
        end
        idle(1);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus process never completes.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
